// File: rtl/piso_tx.sv
// ============================================================================
//  Module   : piso_tx
//  Purpose  : Parallel-in/serial-out transmitter, LSB first, with per-bit hold
//             and a sample strobe in the last cycle of each bit period.
//             Optional even-parity bit when PISO_TX_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_tx #(
   parameter int WIDTH = 8,
   parameter int HOLD  = 2
) (
   input  logic             clk,
   input  logic             rest,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             d_out,
   output logic             strobe,
   output logic             busy,
   output logic             done
);

`ifdef PISO_TX_PARITY_EN
   localparam int c_BITS = WIDTH + 1;
`else
   localparam int c_BITS = WIDTH;
`endif
   localparam int c_BW   = $clog2(WIDTH + 1);
   localparam int c_HW   = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

   localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(c_BITS - 1);
   localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD - 1);
   localparam logic            c_HOLD_ONE  = (HOLD == 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state, w_state_nx;
   logic [c_BITS-1:0] r_shift, w_shift_nx, w_load_word;
   logic [c_BW-1:0]   r_bit_cnt, w_bit_nx;
   logic [c_HW-1:0]   r_hold_cnt, w_hold_nx;
   logic              w_d_nx, w_strobe_nx, w_busy_nx, w_done_nx, w_ready_nx;

`ifdef PISO_TX_PARITY_EN
   assign w_load_word = {^din, din};
`else
   assign w_load_word = din;
`endif

   // Outputs are decoded from the next state so they become valid on the
   // same edge that enters that state.
   always_comb begin
      w_state_nx  = r_state;
      w_shift_nx  = r_shift;
      w_bit_nx    = r_bit_cnt;
      w_hold_nx   = r_hold_cnt;
      w_d_nx      = 1'b0;
      w_strobe_nx = 1'b0;
      w_busy_nx   = 1'b0;
      w_done_nx   = 1'b0;
      w_ready_nx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready_nx = 1'b1;
            if (load_valid && load_ready) begin
               w_state_nx  = S_SHIFT;
               w_shift_nx  = w_load_word;
               w_bit_nx    = '0;
               w_hold_nx   = '0;
               w_ready_nx  = 1'b0;
               w_busy_nx   = 1'b1;
               w_d_nx      = w_load_word[0];
               w_strobe_nx = c_HOLD_ONE;
            end
         end
         S_SHIFT: begin
            w_busy_nx = 1'b1;
            if (r_hold_cnt == c_HOLD_LAST) begin
               if (r_bit_cnt == c_BIT_LAST) begin
                  w_state_nx = S_DONE;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_shift_nx  = r_shift >> 1;
                  w_bit_nx    = r_bit_cnt + 1'b1;
                  w_hold_nx   = '0;
                  w_d_nx      = r_shift[1];
                  w_strobe_nx = c_HOLD_ONE;
               end
            end else begin
               w_hold_nx   = r_hold_cnt + 1'b1;
               w_d_nx      = r_shift[0];
               w_strobe_nx = ((r_hold_cnt + 1'b1) == c_HOLD_LAST);
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
            w_ready_nx = 1'b1;
         end
         default: begin
            w_state_nx = S_IDLE;
            w_ready_nx = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_hold_cnt <= '0;
         d_out      <= 1'b0;
         strobe     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nx;
         r_shift    <= w_shift_nx;
         r_bit_cnt  <= w_bit_nx;
         r_hold_cnt <= w_hold_nx;
         d_out      <= w_d_nx;
         strobe     <= w_strobe_nx;
         busy       <= w_busy_nx;
         done       <= w_done_nx;
         load_ready <= w_ready_nx;
      end
   end

endmodule

`default_nettype wire
